// File: rtl/psum_accum_drain.sv
// psum_accum_drain: sums 6-lane PE cluster results over NUM_PASSES passes,
// then drains the per-lane sums one word at a time on a valid/ready port.
// Results arriving while draining are dropped and flagged in drop_err.
// Optional feature macro: RELU_EN (negative sums are output as zero).
module psum_accum_drain #(
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned LANES      = 6,
  parameter int unsigned NUM_PASSES = 3,
  parameter int unsigned SUM_WIDTH  = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [LANES-1:0]                   in_fin,
  input  logic [LANES*ACC_WIDTH-1:0]         in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SUM_WIDTH-1:0]               out_data,
  output logic [2:0]                         out_lane,
  output logic                               out_last,
  output logic [$clog2(NUM_PASSES+1)-1:0]    pass_cnt,
  output logic                               drop_err,
  output logic                               sat_flag
);

  localparam int unsigned PCW = $clog2(NUM_PASSES + 1);
  localparam logic [2:0] LastLane = 3'(LANES - 1);
  localparam logic [SUM_WIDTH-1:0] SumMin = {1'b1, {(SUM_WIDTH-1){1'b0}}};
  localparam logic [SUM_WIDTH-1:0] SumMax = ~SumMin;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_t;

  state_t               r_state;
  logic [SUM_WIDTH-1:0] r_acc [LANES];
  logic [PCW-1:0]       r_pass_cnt;
  logic                 r_out_valid;
  logic [SUM_WIDTH-1:0] r_out_data;
  logic [2:0]           r_out_lane;
  logic                 r_out_last;
  logic                 r_drop_err;
  logic                 r_sat_flag;

  logic [SUM_WIDTH-1:0] w_ext [LANES];
  logic [SUM_WIDTH:0]   w_wide [LANES];
  logic [SUM_WIDTH-1:0] w_sat [LANES];
  logic [LANES-1:0]     w_ovf;
  logic                 w_fin;
  logic                 w_last_hs;
  logic                 w_load;
  logic                 w_accum;
  logic                 w_drain_go;
  logic [SUM_WIDTH-1:0] w_first_word;
  logic [2:0]           w_next_lane;
  logic [SUM_WIDTH-1:0] w_next_word;

  // Output-side clamp; accumulators always keep the signed sum.
  function automatic logic [SUM_WIDTH-1:0] f_out(input logic [SUM_WIDTH-1:0] v);
`ifdef RELU_EN
    f_out = v[SUM_WIDTH-1] ? '0 : v;
`else
    f_out = v;
`endif
  endfunction

  // Per-lane sign extension and saturating add of the incoming result.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_ext[k]  = SUM_WIDTH'($signed(in_data[k*ACC_WIDTH +: ACC_WIDTH]));
      w_wide[k] = {r_acc[k][SUM_WIDTH-1], r_acc[k]} + {w_ext[k][SUM_WIDTH-1], w_ext[k]};
      w_ovf[k]  = w_wide[k][SUM_WIDTH] ^ w_wide[k][SUM_WIDTH-1];
      if (w_ovf[k]) begin
        w_sat[k] = w_wide[k][SUM_WIDTH] ? SumMin : SumMax;
      end else begin
        w_sat[k] = w_wide[k][SUM_WIDTH-1:0];
      end
    end
  end

  // Control decode: a result coinciding with the last-word handshake opens the next group.
  always_comb begin
    w_fin        = |in_fin;
    w_last_hs    = (r_state == StDrain) && out_ready && (r_out_lane == LastLane);
    w_load       = w_fin && ((r_state == StIdle) || w_last_hs);
    w_accum      = w_fin && (r_state == StAccum);
    w_drain_go   = (w_load && (NUM_PASSES == 1)) ||
                   (w_accum && (r_pass_cnt == PCW'(NUM_PASSES - 1)));
    w_first_word = (r_state == StAccum) ? w_sat[0] : w_ext[0];
    w_next_lane  = r_out_lane + 3'd1;
    w_next_word  = r_acc[w_next_lane];
  end

  // FSM with registered outputs; later assignments in the block take precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
      r_pass_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_last  <= 1'b0;
      r_drop_err  <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else if (flush) begin
      r_state     <= StIdle;
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
      r_pass_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_last  <= 1'b0;
      r_drop_err  <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else begin
      if ((r_state == StDrain) && w_fin && !w_last_hs) r_drop_err <= 1'b1;
      if ((r_state == StDrain) && out_ready) begin
        if (r_out_lane == LastLane) begin
          for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
          r_pass_cnt  <= '0;
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_lane  <= '0;
          r_out_last  <= 1'b0;
        end else begin
          r_out_lane <= w_next_lane;
          r_out_last <= (w_next_lane == LastLane);
          r_out_data <= f_out(w_next_word);
        end
      end
      if (w_load) begin
        for (int k = 0; k < LANES; k++) r_acc[k] <= w_ext[k];
        r_pass_cnt <= PCW'(1);
        r_state    <= StAccum;
      end
      if (w_accum) begin
        for (int k = 0; k < LANES; k++) r_acc[k] <= w_sat[k];
        r_pass_cnt <= r_pass_cnt + PCW'(1);
        if (|w_ovf) r_sat_flag <= 1'b1;
      end
      if (w_drain_go) begin
        r_state     <= StDrain;
        r_out_valid <= 1'b1;
        r_out_lane  <= '0;
        r_out_last  <= (LANES == 1);
        r_out_data  <= f_out(w_first_word);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_lane  = r_out_lane;
  assign out_last  = r_out_last;
  assign pass_cnt  = r_pass_cnt;
  assign drop_err  = r_drop_err;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_psum_accum_drain.sv
// Directed bench for psum_accum_drain: default instance (SUM_WIDTH=20) plus a
// SUM_WIDTH=16 instance for the saturation case. Honors RELU_EN if defined.
module tb_psum_accum_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  in_fin;
  logic [95:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic [2:0]  out_lane;
  logic        out_last;
  logic [1:0]  pass_cnt;
  logic        drop_err;
  logic        sat_flag;

  logic        s_flush;
  logic [5:0]  s_fin;
  logic [95:0] s_data;
  logic        s_ready;
  logic        s_valid;
  logic [15:0] s_out;
  logic [2:0]  s_lane;
  logic        s_last;
  logic [1:0]  s_pass;
  logic        s_drop;
  logic        s_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_accum_drain u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_fin(in_fin), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .pass_cnt(pass_cnt), .drop_err(drop_err), .sat_flag(sat_flag)
  );

  psum_accum_drain #(.SUM_WIDTH(16)) u_sat (
    .clk(clk), .rst(rst), .flush(s_flush), .in_fin(s_fin), .in_data(s_data),
    .out_valid(s_valid), .out_ready(s_ready), .out_data(s_out), .out_lane(s_lane),
    .out_last(s_last), .pass_cnt(s_pass), .drop_err(s_drop), .sat_flag(s_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pack(input int base, input int step);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[k*16 +: 16] = 16'(base + step * k);
    return r;
  endfunction

  // Three back-to-back passes of the same data; returns with word 0 on the port.
  task automatic run_group(input logic [95:0] d);
    in_data = d;
    in_fin  = 6'h3F;
    tick();
    tick();
    tick();
    in_fin  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_fin = '0; in_data = '0; out_ready = 1'b1;
    s_flush = 1'b0; s_fin = '0; s_data = '0; s_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", out_valid); end
    checks++; if (out_data !== 20'd0) begin errors++; $display("FAIL rst_data got %0h want 0", out_data); end
    checks++; if (out_lane !== 3'd0) begin errors++; $display("FAIL rst_lane got %0h want 0", out_lane); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0h want 0", out_last); end
    checks++; if (pass_cnt !== 2'd0) begin errors++; $display("FAIL rst_pass got %0h want 0", pass_cnt); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop got %0h want 0", drop_err); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rst_sat got %0h want 0", sat_flag); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    in_data = pack(1, 1);
    in_fin  = 6'h3F;
    tick();
    checks++; if (pass_cnt !== 2'd1) begin errors++; $display("FAIL basic_pass1 got %0d want 1", pass_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_novalid got %0h want 0", out_valid); end
    tick();
    checks++; if (pass_cnt !== 2'd2) begin errors++; $display("FAIL basic_pass2 got %0d want 2", pass_cnt); end
    tick();
    in_fin = '0;
    checks++; if (pass_cnt !== 2'd3) begin errors++; $display("FAIL basic_pass3 got %0d want 3", pass_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %0h want 1", i, out_valid); end
      checks++; if (out_lane !== 3'(i)) begin errors++; $display("FAIL basic_lane[%0d] got %0d want %0d", i, out_lane, i); end
      checks++; if (out_data !== 20'(3 * (i + 1))) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", i, out_data, 3 * (i + 1)); end
      checks++; if (out_last !== (i == 5)) begin errors++; $display("FAIL basic_last[%0d] got %0h want %0h", i, out_last, (i == 5)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid got %0h want 0", out_valid); end
    checks++; if (pass_cnt !== 2'd0) begin errors++; $display("FAIL basic_end_pass got %0d want 0", pass_cnt); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat got %0h want 0", sat_flag); end
  endtask

  task automatic test_backpressure();
    int e;
    int stall;
    e = 0;
    stall = 0;
    run_group(pack(1, 1));
    for (int c = 0; c < 10; c++) begin
      out_ready = !(e == 2 && stall < 4);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h want 1", c, out_valid); end
      checks++; if (out_lane !== 3'(e)) begin errors++; $display("FAIL bp_lane[%0d] got %0d want %0d", c, out_lane, e); end
      checks++; if (out_data !== 20'(3 * (e + 1))) begin errors++; $display("FAIL bp_data[%0d] got %0d want %0d", c, out_data, 3 * (e + 1)); end
      checks++; if (out_last !== (e == 5)) begin errors++; $display("FAIL bp_last[%0d] got %0h want %0h", c, out_last, (e == 5)); end
      tick();
      if (out_ready) e++;
      else stall++;
    end
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0h want 0", out_valid); end
  endtask

  task automatic test_drop();
    run_group(pack(10, 10));
    for (int i = 0; i < 6; i++) begin
      in_fin  = (i == 1) ? 6'h3F : 6'h00;
      in_data = pack(100, 0);
      checks++; if (out_data !== 20'(30 * (i + 1))) begin errors++; $display("FAIL drop_data[%0d] got %0d want %0d", i, out_data, 30 * (i + 1)); end
      checks++; if (out_lane !== 3'(i)) begin errors++; $display("FAIL drop_lane[%0d] got %0d want %0d", i, out_lane, i); end
      tick();
    end
    in_fin = '0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_flag got %0h want 1", drop_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_end_valid got %0h want 0", out_valid); end
    in_data = pack(1, 0);
    in_fin  = 6'h01;
    tick();
    in_fin  = '0;
    checks++; if (pass_cnt !== 2'd1) begin errors++; $display("FAIL drop_newgroup_pass got %0d want 1", pass_cnt); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky got %0h want 1", drop_err); end
  endtask

  task automatic test_flush();
    in_fin = 6'h20;
    tick();
    in_fin = '0;
    checks++; if (pass_cnt !== 2'd2) begin errors++; $display("FAIL flush_pre_pass got %0d want 2", pass_cnt); end
    flush  = 1'b1;
    in_fin = 6'h3F;
    tick();
    flush  = 1'b0;
    in_fin = '0;
    checks++; if (pass_cnt !== 2'd0) begin errors++; $display("FAIL flush_pass got %0d want 0", pass_cnt); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL flush_drop got %0h want 0", drop_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h want 0", out_valid); end
    run_group(pack(2, 0));
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid[%0d] got %0h want 1", i, out_valid); end
      checks++; if (out_data !== 20'd6) begin errors++; $display("FAIL flush_data[%0d] got %0d want 6", i, out_data); end
      tick();
    end
  endtask

  task automatic test_signed();
    logic [95:0] d;
    logic [19:0] exp0;
    d = '0;
    d[15:0] = 16'hFFFB;
`ifdef RELU_EN
    exp0 = 20'd0;
`else
    exp0 = 20'hFFFF1;
`endif
    run_group(d);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_data !== ((i == 0) ? exp0 : 20'd0)) begin
        errors++; $display("FAIL signed_data[%0d] got %0h want %0h", i, out_data, (i == 0) ? exp0 : 20'd0);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    run_group(pack(1, 1));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        in_fin  = 6'h3F;
        in_data = pack(7, 0);
      end
      checks++; if (out_data !== 20'(3 * (i + 1))) begin errors++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, out_data, 3 * (i + 1)); end
      tick();
    end
    in_fin = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %0h want 0", out_valid); end
    checks++; if (pass_cnt !== 2'd1) begin errors++; $display("FAIL b2b_pass got %0d want 1", pass_cnt); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL b2b_drop got %0h want 0", drop_err); end
    in_fin = 6'h3F;
    tick();
    tick();
    in_fin = '0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0h want 1", out_valid); end
    checks++; if (out_data !== 20'd21) begin errors++; $display("FAIL b2b_word0 got %0d want 21", out_data); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %0h want 0", out_valid); end
  endtask

  task automatic test_sat();
    logic [15:0] exp1;
`ifdef RELU_EN
    exp1 = 16'h0000;
`else
    exp1 = 16'h8000;
`endif
    checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL sat_pre got %0h want 0", s_sat); end
    s_data = '0;
    s_data[15:0]  = 16'h7FFF;
    s_data[31:16] = 16'h8000;
    s_fin = 6'h3F;
    tick();
    tick();
    tick();
    s_fin = '0;
    checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %0h want 1", s_sat); end
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0h want 1", s_valid); end
    checks++; if (s_out !== 16'h7FFF) begin errors++; $display("FAIL sat_max got %0h want 7fff", s_out); end
    tick();
    checks++; if (s_out !== exp1) begin errors++; $display("FAIL sat_min got %0h want %0h", s_out, exp1); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL sat_end_valid got %0h want 0", s_valid); end
    checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL sat_sticky got %0h want 1", s_sat); end
  endtask

  task automatic test_reset_mid_drain();
    run_group(pack(1, 1));
    tick();
    tick();
    checks++; if (out_lane !== 3'd2) begin errors++; $display("FAIL rmd_lane_pre got %0d want 2", out_lane); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmd_valid got %0h want 0", out_valid); end
    checks++; if (out_data !== 20'd0) begin errors++; $display("FAIL rmd_data got %0h want 0", out_data); end
    checks++; if (out_lane !== 3'd0) begin errors++; $display("FAIL rmd_lane got %0d want 0", out_lane); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmd_last got %0h want 0", out_last); end
    checks++; if (pass_cnt !== 2'd0) begin errors++; $display("FAIL rmd_pass got %0d want 0", pass_cnt); end
    checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL rmd_sat got %0h want 0", s_sat); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmd_after_valid got %0h want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_flush();
    test_signed();
    test_back_to_back();
    test_sat();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
